seg_scan_driver: RTL



---
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: BCD digits and controls in,
// multiplexed 7-segment drive and frame marker out.
interface seg_scan_driver_if;
  logic [3:0] num_in0;
  logic [3:0] num_in1;
  logic [3:0] num_in2;
  logic [3:0] num_in3;
  logic       hold;
  logic       blank_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;
  logic       frame_done;

  modport master (
    output num_in0, num_in1, num_in2, num_in3, hold, blank_en,
    input  seg, dp, dig, frame_done
  );

  modport slave (
    input  num_in0, num_in1, num_in2, num_in3, hold, blank_en,
    output seg, dp, dig, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot, lap hold,
// leading-zero blanking, fixed decimal point and dead time between digits.
//
// state | meaning
// GAP   | first DEAD cycles of a slot, every digit enable off
// SHOW  | remainder of the slot, digit idx enabled and decoded
module seg_scan_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD        = 16,
  parameter int DP_POS      = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input logic                clk,
  input logic                sys_rst_n,
  seg_scan_driver_if.slave   io_bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PCNT_DEAD = PW'(DEAD);
  localparam logic [1:0]    DP_IDX    = 2'(DP_POS);
  localparam logic          BLK_OK3   = (DP_POS < 3);
  localparam logic          BLK_OK2   = (DP_POS < 2);
  localparam logic          BLK_OK1   = (DP_POS < 1);

  typedef enum logic {ST_GAP, ST_SHOW} state_t;
  localparam state_t ST_RST = (DEAD == 0) ? ST_SHOW : ST_GAP;

  logic [PW-1:0]     r_pcnt;
  logic [PW-1:0]     w_pcnt_nxt;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_snap;
  logic              r_frame_done;
  logic              w_tick;
  logic              w_frame_tick;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_blank3;
  logic              w_blank2;
  logic              w_blank1;
  logic [3:0]        w_blank;
  logic [3:0]        w_cur;
  logic [6:0]        w_seg_dec;
  logic [3:0]        w_dig_l;
  logic [6:0]        w_seg_l;
  logic              w_dp_l;
  logic [3:0]        r_dig;
  logic [6:0]        r_seg;
  logic              r_dp;

  assign w_tick       = (r_pcnt == PCNT_LAST);
  assign w_frame_tick = w_tick && (r_idx == 2'd3);
  assign w_pcnt_nxt   = w_tick ? '0 : r_pcnt + 1'b1;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pcnt       <= '0;
      r_idx        <= 2'd0;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pcnt       <= w_pcnt_nxt;
      r_frame_done <= w_frame_tick;
      if (w_tick)
        r_idx <= r_idx + 2'd1;
      // The frame boundary is the only load point, so a frame never mixes values.
      if (w_frame_tick && !io_bus.hold)
        r_snap <= {io_bus.num_in3, io_bus.num_in2, io_bus.num_in1, io_bus.num_in0};
    end
  end

  // Blanking ripples down from the most significant digit.
  assign w_blank3 = BLK_OK3 && io_bus.blank_en && (r_snap[3] == 4'd0);
  assign w_blank2 = BLK_OK2 && w_blank3 && (r_snap[2] == 4'd0);
  assign w_blank1 = BLK_OK1 && w_blank2 && (r_snap[1] == 4'd0);
  assign w_blank  = {w_blank3, w_blank2, w_blank1, 1'b0};

  assign w_cur = r_snap[r_idx];

  always_comb begin
    w_seg_dec = 7'b1000000;
    unique case (w_cur)
      4'd0:    w_seg_dec = 7'b0111111;
      4'd1:    w_seg_dec = 7'b0000110;
      4'd2:    w_seg_dec = 7'b1011011;
      4'd3:    w_seg_dec = 7'b1001111;
      4'd4:    w_seg_dec = 7'b1100110;
      4'd5:    w_seg_dec = 7'b1101101;
      4'd6:    w_seg_dec = 7'b1111101;
      4'd7:    w_seg_dec = 7'b0000111;
      4'd8:    w_seg_dec = 7'b1111111;
      4'd9:    w_seg_dec = 7'b1101111;
      default: w_seg_dec = 7'b1000000;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_state <= ST_RST;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dig_l     = 4'b0000;
    w_seg_l     = 7'b0000000;
    w_dp_l      = 1'b0;
    if (w_pcnt_nxt < PCNT_DEAD)
      w_state_nxt = ST_GAP;
    else
      w_state_nxt = ST_SHOW;
    unique case (r_state)
      ST_GAP: begin
        w_dig_l = 4'b0000;
      end
      ST_SHOW: begin
        w_dig_l = 4'b0001 << r_idx;
        if (!w_blank[r_idx]) begin
          w_seg_l = w_seg_dec;
          w_dp_l  = (r_idx == DP_IDX);
        end
      end
      default: begin
        w_dig_l = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dig <= {4{DIG_ACT_LOW}};
      r_seg <= {7{SEG_ACT_LOW}};
      r_dp  <= SEG_ACT_LOW;
    end else begin
      r_dig <= w_dig_l ^ {4{DIG_ACT_LOW}};
      r_seg <= w_seg_l ^ {7{SEG_ACT_LOW}};
      r_dp  <= w_dp_l ^ SEG_ACT_LOW;
    end
  end

  assign io_bus.dig        = r_dig;
  assign io_bus.seg        = r_seg;
  assign io_bus.dp         = r_dp;
  assign io_bus.frame_done = r_frame_done;

endmodule
